meas_averager: RTL and testbench



---
 rtl/meas_averager.sv | 168 ++++++++++++++++
 tb/tb_meas_averager.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_averager.sv
`default_nettype none
// ============================================================================
//  Module   : meas_averager
//  Purpose  : Averages 2^n amplitude/phase sample pairs from the IQ
//             demodulator. Each measurement first discards a programmable
//             number of settling samples. The averaged result is held for
//             the SPI register map with a level meas_done flag.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   hs_clk domain clock
//    rst         in   synchronous active-low reset
//    start       in   pulse: begin measurement, latch avg_log2/settle_cnt
//    abort       in   pulse: return to idle without a result
//    avg_log2    in   averaging exponent (clamped to MAX_LOG2)
//    settle_cnt  in   valid samples to discard before accumulating
//    in_valid    in   strobe qualifying in_amp/in_phs
//    in_amp      in   amplitude difference, unsigned
//    in_phs      in   phase difference, two's complement
//    result_ack  in   pulse: clears meas_done
//    busy        out  measurement in progress (settling or accumulating)
//    meas_done   out  result available
//    out_amp     out  averaged amplitude, unsigned
//    out_phs     out  averaged phase, two's complement
//    sample_idx  out  samples accumulated in the current run
// ============================================================================
module meas_averager #(
    parameter int SIG_WIDTH    = 12,
    parameter int MAX_LOG2     = 10,
    parameter int SETTLE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [3:0]              avg_log2,
    input  logic [SETTLE_WIDTH-1:0] settle_cnt,
    input  logic                    in_valid,
    input  logic [SIG_WIDTH-1:0]    in_amp,
    input  logic [SIG_WIDTH-1:0]    in_phs,
    input  logic                    result_ack,
    output logic                    busy,
    output logic                    meas_done,
    output logic [SIG_WIDTH-1:0]    out_amp,
    output logic [SIG_WIDTH-1:0]    out_phs,
    output logic [MAX_LOG2:0]       sample_idx
);

    // Worst case is 2^MAX_LOG2 full-scale samples, so this width cannot wrap.
    localparam int         c_acc_w = SIG_WIDTH + MAX_LOG2;
    localparam logic [3:0] c_max_n = 4'(MAX_LOG2);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_ACCUM  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [3:0]                r_n;
    logic [SETTLE_WIDTH-1:0]   r_settle;
    logic [c_acc_w-1:0]        r_acc_amp;
    logic signed [c_acc_w-1:0] r_acc_phs;
    logic [MAX_LOG2:0]         r_sample_idx;
    logic                      r_meas_done;
    logic [SIG_WIDTH-1:0]      r_out_amp;
    logic [SIG_WIDTH-1:0]      r_out_phs;

    logic [3:0]                w_n_clamp;
    logic [MAX_LOG2:0]         w_target;
    logic [MAX_LOG2:0]         w_idx_inc;
    logic                      w_busy;
    logic [c_acc_w-1:0]        w_amp_shift;
    logic signed [c_acc_w-1:0] w_phs_shift;

    assign w_n_clamp   = (avg_log2 > c_max_n) ? c_max_n : avg_log2;
    assign w_target    = {{MAX_LOG2{1'b0}}, 1'b1} << r_n;
    assign w_idx_inc   = r_sample_idx + 1'b1;
    assign w_busy      = (r_state == S_SETTLE) || (r_state == S_ACCUM);
    assign w_amp_shift = r_acc_amp >> r_n;
    // Arithmetic shift rounds toward minus infinity, matching floor division.
    assign w_phs_shift = r_acc_phs >>> r_n;

    // ------------------------------------------------------------------------
    // Next-state logic. abort outranks start, so an abort from idle also
    // swallows a coincident start.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else if (start) begin
            w_state_nxt = (settle_cnt != '0) ? S_SETTLE : S_ACCUM;
        end else begin
            case (r_state)
                S_SETTLE: if (in_valid && (r_settle == SETTLE_WIDTH'(1))) w_state_nxt = S_ACCUM;
                S_ACCUM:  if (in_valid && (w_idx_inc == w_target))         w_state_nxt = S_DONE;
                S_DONE:   w_state_nxt = S_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_n          <= '0;
            r_settle     <= '0;
            r_acc_amp    <= '0;
            r_acc_phs    <= '0;
            r_sample_idx <= '0;
            r_meas_done  <= 1'b0;
            r_out_amp    <= '0;
            r_out_phs    <= '0;
        end else begin
            // A completed accumulation is always published; abort and start
            // only affect runs that are still in progress.
            if (r_state == S_DONE) begin
                r_out_amp <= w_amp_shift[SIG_WIDTH-1:0];
                r_out_phs <= w_phs_shift[SIG_WIDTH-1:0];
            end

            // start clears the flag for the new run; otherwise a set in the
            // DONE cycle beats a coincident result_ack.
            if (start && !abort) begin
                r_meas_done <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_meas_done <= 1'b1;
            end else if (result_ack) begin
                r_meas_done <= 1'b0;
            end

            if (!abort) begin
                if (start) begin
                    r_n          <= w_n_clamp;
                    r_settle     <= settle_cnt;
                    r_acc_amp    <= '0;
                    r_acc_phs    <= '0;
                    r_sample_idx <= '0;
                end else if (in_valid && (r_state == S_SETTLE)) begin
                    r_settle <= r_settle - 1'b1;
                end else if (in_valid && (r_state == S_ACCUM)) begin
                    r_acc_amp    <= r_acc_amp + {{MAX_LOG2{1'b0}}, in_amp};
                    r_acc_phs    <= r_acc_phs + $signed({{MAX_LOG2{in_phs[SIG_WIDTH-1]}}, in_phs});
                    r_sample_idx <= w_idx_inc;
                end
            end
        end
    end

    assign busy       = w_busy;
    assign meas_done  = r_meas_done;
    assign out_amp    = r_out_amp;
    assign out_phs    = r_out_phs;
    assign sample_idx = r_sample_idx;

endmodule
`default_nettype wire

// File: tb/tb_meas_averager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_meas_averager
//  Purpose  : Directed, table-driven self-checking bench for meas_averager.
//  Revision : 1.0  initial release
// ============================================================================
module tb_meas_averager;

    localparam int SW  = 12;
    localparam int ML  = 10;
    localparam int STW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [3:0]     avg_log2;
    logic [STW-1:0] settle_cnt;
    logic           in_valid;
    logic [SW-1:0]  in_amp;
    logic [SW-1:0]  in_phs;
    logic           result_ack;
    logic           busy;
    logic           meas_done;
    logic [SW-1:0]  out_amp;
    logic [SW-1:0]  out_phs;
    logic [ML:0]    sample_idx;

    int checks = 0;
    int errors = 0;

    always #2 clk = ~clk;

    meas_averager #(
        .SIG_WIDTH    (SW),
        .MAX_LOG2     (ML),
        .SETTLE_WIDTH (STW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .avg_log2   (avg_log2),
        .settle_cnt (settle_cnt),
        .in_valid   (in_valid),
        .in_amp     (in_amp),
        .in_phs     (in_phs),
        .result_ack (result_ack),
        .busy       (busy),
        .meas_done  (meas_done),
        .out_amp    (out_amp),
        .out_phs    (out_phs),
        .sample_idx (sample_idx)
    );

    typedef struct {
        logic [3:0]          avg;
        logic [7:0]          settle;
        int                  nfeed;
        logic [7:0][SW-1:0]  amp;
        logic [7:0][SW-1:0]  phs;
        int                  e_amp;
        int                  e_phs;
        int                  e_idx;
    } vec_t;

    vec_t vt[6];

    function automatic logic [SW-1:0] s12(input int x);
        return x[SW-1:0];
    endfunction

    function automatic int phs_int();
        return int'($signed(out_phs));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int a, input int p);
        in_valid = 1'b1;
        in_amp   = s12(a);
        in_phs   = s12(p);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int avg, input int settle);
        start      = 1'b1;
        avg_log2   = 4'(avg);
        settle_cnt = STW'(settle);
        tick();
        start      = 1'b0;
    endtask

    task automatic check_result(input string nm, input int ea, input int ep, input int ei);
        chk({nm, "_done_early"}, int'(meas_done), 0);
        tick();
        chk({nm, "_done"}, int'(meas_done), 1);
        chk({nm, "_amp"},  int'(out_amp), ea);
        chk({nm, "_phs"},  phs_int(), ep);
        chk({nm, "_idx"},  int'(sample_idx), ei);
        chk({nm, "_busy"}, int'(busy), 0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        pulse_start(int'(v.avg), int'(v.settle));
        chk({nm, "_busy_start"}, int'(busy), 1);
        for (int i = 0; i < v.nfeed; i++) begin
            feed(int'(v.amp[i]), int'($signed(v.phs[i])));
        end
        check_result(nm, v.e_amp, v.e_phs, v.e_idx);
    endtask

    task automatic run_full(input int avg, input string nm);
        pulse_start(avg, 0);
        in_valid = 1'b1;
        in_amp   = s12(4095);
        in_phs   = s12(-2048);
        for (int i = 0; i < 1024; i++) tick();
        in_valid = 1'b0;
        check_result(nm, 4095, -2048, 1024);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; avg_log2 = '0; settle_cnt = '0;
        in_valid = 1'b0; in_amp = '0; in_phs = '0; result_ack = 1'b0;

        // Vector table
        vt[0].avg = 4'd2; vt[0].settle = 8'd0; vt[0].nfeed = 4;
        vt[0].amp = '0;   vt[0].phs = '0;
        vt[0].amp[0] = s12(100); vt[0].amp[1] = s12(101); vt[0].amp[2] = s12(102); vt[0].amp[3] = s12(103);
        vt[0].phs[0] = s12(10);  vt[0].phs[1] = s12(-10); vt[0].phs[2] = s12(20);  vt[0].phs[3] = s12(-20);
        vt[0].e_amp = 101; vt[0].e_phs = 0; vt[0].e_idx = 4;

        vt[1].avg = 4'd1; vt[1].settle = 8'd3; vt[1].nfeed = 5;
        vt[1].amp = '0;   vt[1].phs = '0;
        vt[1].amp[0] = s12(4000); vt[1].amp[1] = s12(4000); vt[1].amp[2] = s12(4000);
        vt[1].amp[3] = s12(10);   vt[1].amp[4] = s12(20);
        vt[1].e_amp = 15; vt[1].e_phs = 0; vt[1].e_idx = 2;

        vt[2].avg = 4'd1; vt[2].settle = 8'd0; vt[2].nfeed = 2;
        vt[2].amp = '0;   vt[2].phs = '0;
        vt[2].amp[0] = s12(7);  vt[2].amp[1] = s12(8);
        vt[2].phs[0] = s12(-1); vt[2].phs[1] = s12(0);
        vt[2].e_amp = 7; vt[2].e_phs = -1; vt[2].e_idx = 2;

        vt[3].avg = 4'd0; vt[3].settle = 8'd0; vt[3].nfeed = 1;
        vt[3].amp = '0;   vt[3].phs = '0;
        vt[3].amp[0] = s12(1234); vt[3].phs[0] = s12(-5);
        vt[3].e_amp = 1234; vt[3].e_phs = -5; vt[3].e_idx = 1;

        vt[4].avg = 4'd1; vt[4].settle = 8'd2; vt[4].nfeed = 4;
        vt[4].amp = '0;   vt[4].phs = '0;
        vt[4].amp[0] = s12(1);   vt[4].amp[1] = s12(2);   vt[4].amp[2] = s12(3);  vt[4].amp[3] = s12(4);
        vt[4].phs[0] = s12(100); vt[4].phs[1] = s12(100); vt[4].phs[2] = s12(-7); vt[4].phs[3] = s12(-8);
        vt[4].e_amp = 3; vt[4].e_phs = -8; vt[4].e_idx = 2;

        vt[5].avg = 4'd3; vt[5].settle = 8'd1; vt[5].nfeed = 8;
        vt[5].amp = '0;   vt[5].phs = '0;
        for (int i = 0; i < 8; i++) begin
            vt[5].amp[i] = s12(i + 1);
            vt[5].phs[i] = s12(-1);
        end
        vt[5].amp[0] = s12(999);
        vt[5].e_amp = 4; vt[5].e_phs = -1; vt[5].e_idx = 7;

        // Reset state
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(meas_done), 0);
        chk("rst_amp",  int'(out_amp), 0);
        chk("rst_phs",  phs_int(), 0);
        chk("rst_idx",  int'(sample_idx), 0);

        // Samples in IDLE are dropped
        feed(500, 50); feed(600, 60); feed(700, 70);
        chk("idle_idx",  int'(sample_idx), 0);
        chk("idle_busy", int'(busy), 0);

        // Table-driven runs (vector 5: one settle sample leaves seven to add,
        // so the run needs one more sample beyond the table)
        for (int k = 0; k < 5; k++) begin
            run_vec(vt[k], $sformatf("vec%0d", k));
        end
        pulse_start(3, 1);
        for (int i = 0; i < 8; i++) feed(int'(vt[5].amp[i]), -1);
        feed(9, -1);
        // accumulated amps 2..9 = 44 -> 5; phases eight times -1 -> -1
        check_result("vec5", 5, -1, 8);

        // Phase rounding then result_ack
        run_vec(vt[2], "round");
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ack_done", int'(meas_done), 0);
        chk("ack_amp",  int'(out_amp), 7);
        chk("ack_phs",  phs_int(), -1);

        // Full-scale averaging, then clamped exponent
        run_full(10, "full10");
        run_full(12, "full12");

        // Abort mid-ACCUM
        pulse_start(2, 0);
        feed(1, 1); feed(1, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(meas_done), 0);
        tick(); tick();
        chk("abort_done_late", int'(meas_done), 0);
        chk("abort_amp", int'(out_amp), 4095);
        chk("abort_phs", phs_int(), -2048);

        // Restart mid-ACCUM; coincident in_valid is ignored
        pulse_start(2, 0);
        feed(1000, 1); feed(1000, 1);
        in_valid = 1'b1; in_amp = s12(3000); in_phs = s12(300);
        pulse_start(1, 0);
        in_valid = 1'b0;
        chk("restart_idx",  int'(sample_idx), 0);
        chk("restart_busy", int'(busy), 1);
        feed(50, 3); feed(60, 4);
        check_result("restart", 55, 3, 2);

        // result_ack in the DONE cycle loses to the set
        pulse_start(0, 0);
        feed(42, -3);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("ackdone_done", int'(meas_done), 1);
        chk("ackdone_amp",  int'(out_amp), 42);
        chk("ackdone_phs",  phs_int(), -3);

        // Reset mid-ACCUM
        pulse_start(2, 0);
        feed(9, 9); feed(9, 9);
        rst = 1'b0;
        tick();
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(meas_done), 0);
        chk("mrst_amp",  int'(out_amp), 0);
        chk("mrst_phs",  phs_int(), 0);
        chk("mrst_idx",  int'(sample_idx), 0);
        rst = 1'b1;
        feed(9, 9); feed(9, 9);
        tick(); tick();
        chk("mrst_after_done", int'(meas_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
